// File: rtl/ddr_burst_master_pkg.sv
// Shared constants, FSM encoding and 4 KB helper for the DDR burst initiator.
package ddr_burst_master_pkg;

    localparam int BEAT_BYTES  = 8;
    localparam int BEAT_SHIFT  = 3;
    localparam int BOUNDARY_4K = 4096;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_GATE,
        ST_REQ,
        ST_XFER,
        ST_DONE
    } state_e;

    // Whole beats left before the next 4 KB page boundary (1..512).
    function automatic logic [9:0] beats_to_4k(input logic [11:0] byte_off);
        logic [12:0] bytes_left;
        bytes_left = 13'(BOUNDARY_4K) - {1'b0, byte_off};
        return 10'(bytes_left >> BEAT_SHIFT);
    endfunction

endpackage

// File: rtl/ddr_burst_master_len_calc.sv
// Combinational burst length: min(remaining, MAX_BURST), optionally clipped at 4 KB.
// Optional feature macro: BURST_4K_SPLIT_EN.
module ddr_burst_len_calc
    import ddr_burst_master_pkg::*;
#(
    parameter int LEN_WIDTH   = 8,
    parameter int CMD_BEATS_W = 20,
    parameter int MAX_BURST   = 64
) (
    input  logic [CMD_BEATS_W-1:0] remaining,
`ifdef BURST_4K_SPLIT_EN
    input  logic [11:0]            addr_lo,
`endif
    output logic [LEN_WIDTH-1:0]   len
);

    logic [CMD_BEATS_W-1:0] lim;

    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    always_comb begin
        lim = (remaining < CMD_BEATS_W'(MAX_BURST)) ? remaining : CMD_BEATS_W'(MAX_BURST);
`ifdef BURST_4K_SPLIT_EN
        if (CMD_BEATS_W'(beats_to_4k(addr_lo)) < lim) begin
            lim = CMD_BEATS_W'(beats_to_4k(addr_lo));
        end
`endif
        len = LEN_WIDTH'(lim);
    end

endmodule

// File: rtl/ddr_burst_master.sv
// DDR user-burst initiator: splits one transfer command into bursts of at most MAX_BURST beats.
// Optional feature macro: BURST_4K_SPLIT_EN (keeps every burst inside one 4 KB page).
module ddr_burst_master
    import ddr_burst_master_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_SIZE   = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int MAX_BURST   = 64,
    parameter int CMD_BEATS_W = 20
) (
    input  logic                   user_clk,
    input  logic                   user_rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_rw,
    input  logic [ADDR_SIZE-1:0]   cmd_addr,
    input  logic [CMD_BEATS_W-1:0] cmd_beats,
    output logic                   cmd_done,
    output logic                   busy,
    output logic                   err,
    output logic [DATA_WIDTH-1:0]  burst_write_data,
    output logic [ADDR_SIZE-1:0]   burst_write_addr,
    output logic [LEN_WIDTH-1:0]   burst_write_len,
    output logic                   burst_write_req,
    input  logic                   burst_write_valid,
    input  logic                   burst_write_finish,
    input  logic [DATA_WIDTH-1:0]  burst_read_data,
    output logic [ADDR_SIZE-1:0]   burst_read_addr,
    output logic [LEN_WIDTH-1:0]   burst_read_len,
    output logic                   burst_read_req,
    input  logic                   burst_read_valid,
    input  logic                   burst_read_finish,
    input  logic [DATA_WIDTH-1:0]  wr_src_data,
    input  logic [15:0]            wr_src_cnt,
    output logic                   wr_src_pop,
    output logic [DATA_WIDTH-1:0]  rd_dst_data,
    output logic                   rd_dst_valid,
    input  logic [15:0]            rd_dst_space
);

    state_e                 state_q, state_d;
    logic                   rw_q, rw_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [ADDR_SIZE-1:0]   burst_addr_q, burst_addr_d;
    logic [CMD_BEATS_W-1:0] remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH:0]     beat_cnt_q, beat_cnt_d;
    logic                   err_q, err_d;
    logic [DATA_WIDTH-1:0]  rd_data_q, rd_data_d;
    logic                   rd_valid_q, rd_valid_d;

    logic [LEN_WIDTH-1:0]   calc_len;
    logic                   beat_valid, beat_finish, room_ok;
    logic [LEN_WIDTH:0]     beats_total;

    ddr_burst_len_calc #(
        .LEN_WIDTH  (LEN_WIDTH),
        .CMD_BEATS_W(CMD_BEATS_W),
        .MAX_BURST  (MAX_BURST)
    ) u_len_calc (
        .remaining(remaining_q),
`ifdef BURST_4K_SPLIT_EN
        .addr_lo  (addr_q[11:0]),
`endif
        .len      (calc_len)
    );

    assign beat_valid  = rw_q ? burst_write_valid  : burst_read_valid;
    assign beat_finish = rw_q ? burst_write_finish : burst_read_finish;
    assign room_ok     = rw_q ? (wr_src_cnt >= 16'(len_q)) : (rd_dst_space >= 16'(len_q));
    // A finish that coincides with the last valid beat must still count that beat.
    assign beats_total = beat_cnt_q + (LEN_WIDTH + 1)'(beat_valid);

    always_comb begin
        state_d      = state_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        burst_addr_d = burst_addr_q;
        remaining_d  = remaining_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        err_d        = err_q;
        rd_data_d    = burst_read_data;
        rd_valid_d   = (state_q == ST_XFER) && !rw_q && burst_read_valid;

        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                rw_d        = cmd_rw;
                addr_d      = cmd_addr & ~ADDR_SIZE'(BEAT_BYTES - 1);
                remaining_d = cmd_beats;
                state_d     = (cmd_beats == '0) ? ST_DONE : ST_CALC;
            end
            ST_CALC: begin
                len_d        = calc_len;
                burst_addr_d = addr_q;
                state_d      = ST_GATE;
            end
            ST_GATE: if (room_ok) state_d = ST_REQ;
            ST_REQ: begin
                beat_cnt_d = '0;
                state_d    = ST_XFER;
            end
            ST_XFER: begin
                if (beat_valid) beat_cnt_d = beats_total;
                if (beat_finish) begin
                    if (beats_total != {1'b0, len_q}) err_d = 1'b1;
                    addr_d      = addr_q + (ADDR_SIZE'(len_q) << BEAT_SHIFT);
                    remaining_d = remaining_q - CMD_BEATS_W'(len_q);
                    state_d     = (remaining_q == CMD_BEATS_W'(len_q)) ? ST_DONE : ST_CALC;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_q      <= ST_IDLE;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            burst_addr_q <= '0;
            remaining_q  <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            err_q        <= 1'b0;
            // NOTE: the read data register is reset too, because rd_dst_data must read 0 after reset.
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            burst_addr_q <= burst_addr_d;
            remaining_q  <= remaining_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            err_q        <= err_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign cmd_ready        = (state_q == ST_IDLE) && user_rst_n;
    assign busy             = (state_q != ST_IDLE);
    assign cmd_done         = (state_q == ST_DONE);
    assign err              = err_q;
    assign burst_write_data = wr_src_data;
    assign burst_write_addr = burst_addr_q;
    assign burst_write_len  = len_q;
    assign burst_read_addr  = burst_addr_q;
    assign burst_read_len   = len_q;
    assign burst_write_req  = (state_q == ST_REQ) && rw_q;
    assign burst_read_req   = (state_q == ST_REQ) && !rw_q;
    assign wr_src_pop       = (state_q == ST_XFER) && rw_q && burst_write_valid;
    assign rd_dst_data      = rd_data_q;
    assign rd_dst_valid     = rd_valid_q;

endmodule
